// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer family: digit width,
// controller state encoding and a BCD digit validity helper.
package bcd_timer_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
      return digit <= BCD_W'(9);
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a ripple-borrow decrementer; a digit at 0 wraps to 9
// and passes the borrow on to the next more significant digit.
module bcd_digit_dec
   import bcd_timer_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] digit_next,
   output logic             borrow_out
);

   always_comb begin
      digit_next = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit == '0) begin
            digit_next = BCD_W'(9);
            borrow_out = 1'b1;
         end else begin
            digit_next = digit - 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_multichannel_countdown.sv
// Multi-channel BCD lane timer: loads a validated preset from a one-hot
// selected channel and counts it down once per prescaled tick.
module bcd_multichannel_countdown
   import bcd_timer_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter int CHANNELS = 4,
   parameter int TICK_DIV = 50000000
) (
   input  logic                         C_CLK,
   input  logic                         RST,
   input  logic                         C_EN,
   input  logic                         start,
   input  logic                         auto_reload,
   input  logic [CHANNELS-1:0]          ch_sel,
   input  logic [CHANNELS*DIGITS*4-1:0] preset_bus,
   output logic [DIGITS*4-1:0]          remaining,
   output logic                         C_out,
   output logic                         busy,
   output logic                         err,
   output logic [CHANNELS-1:0]          active_ch
);

   localparam int VAL_W = DIGITS * BCD_W;
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   state_t           state;
   logic [PRE_W-1:0] prescaler;
   logic [VAL_W-1:0] preset_latch;
   logic [VAL_W-1:0] sel_preset;
   logic [VAL_W-1:0] dec_value;
   logic [DIGITS:0]  borrow;
   logic             sel_valid;
   logic             accept;
   logic             tick;
   logic             at_zero;

   // A start is only honoured for a single selected lane whose preset is all-BCD.
   always_comb begin
      sel_preset = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (ch_sel[k]) begin
            sel_preset = sel_preset | preset_bus[k*VAL_W +: VAL_W];
         end
      end
      sel_valid = $onehot(ch_sel);
      for (int d = 0; d < DIGITS; d++) begin
         if (!bcd_valid(sel_preset[d*BCD_W +: BCD_W])) begin
            sel_valid = 1'b0;
         end
      end
   end

   assign accept = start && sel_valid;
   assign tick   = (state != IDLE) && C_EN && (prescaler == PRE_LAST);

   // Borrow ripples out of the top digit exactly when every digit is zero.
   assign borrow[0] = 1'b1;
   assign at_zero   = borrow[DIGITS];

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      bcd_digit_dec u_dec (
         .digit      (remaining[g*BCD_W +: BCD_W]),
         .borrow_in  (borrow[g]),
         .digit_next (dec_value[g*BCD_W +: BCD_W]),
         .borrow_out (borrow[g+1])
      );
   end

   always_ff @(posedge C_CLK) begin
      if (!RST) begin
         state        <= IDLE;
         prescaler    <= '0;
         preset_latch <= '0;
         remaining    <= '0;
         C_out        <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
         active_ch    <= '0;
      end else begin
         C_out <= 1'b0;
         err   <= 1'b0;
         if (accept) begin
            remaining    <= sel_preset;
            preset_latch <= sel_preset;
            active_ch    <= ch_sel;
            prescaler    <= '0;
            state        <= C_EN ? RUN : PAUSE;
            busy         <= 1'b1;
         end else begin
            if (start) begin
               err <= 1'b1;
            end
            case (state)
               IDLE: begin
               end
               default: begin
                  state <= C_EN ? RUN : PAUSE;
                  if (tick) begin
                     prescaler <= '0;
                     if (at_zero) begin
                        C_out <= 1'b1;
                        if (auto_reload) begin
                           remaining <= preset_latch;
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        remaining <= dec_value;
                     end
                  end else if (C_EN) begin
                     prescaler <= prescaler + 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_multichannel_countdown.sv
// Directed scenarios plus randomized lock-step comparison against a
// decimal-arithmetic reference model of the lane timer.
module tb_bcd_multichannel_countdown;

   localparam int DIGITS   = 3;
   localparam int CHANNELS = 4;
   localparam int TICK_DIV = 3;
   localparam int VAL_W    = DIGITS * 4;

   logic                      C_CLK = 1'b0;
   logic                      RST = 1'b0;
   logic                      C_EN = 1'b1;
   logic                      start = 1'b0;
   logic                      auto_reload = 1'b0;
   logic [CHANNELS-1:0]       ch_sel = '0;
   logic [CHANNELS*VAL_W-1:0] preset_bus = '0;
   logic [VAL_W-1:0]          remaining;
   logic                      C_out;
   logic                      busy;
   logic                      err;
   logic [CHANNELS-1:0]       active_ch;

   int tests_run = 0;
   int tests_failed = 0;

   int                  m_rem = 0;
   int                  m_preset = 0;
   int                  m_pre = 0;
   bit                  m_busy = 1'b0;
   bit                  m_cout = 1'b0;
   bit                  m_err = 1'b0;
   logic [CHANNELS-1:0] m_active = '0;

   bcd_multichannel_countdown #(
      .DIGITS   (DIGITS),
      .CHANNELS (CHANNELS),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .C_CLK       (C_CLK),
      .RST         (RST),
      .C_EN        (C_EN),
      .start       (start),
      .auto_reload (auto_reload),
      .ch_sel      (ch_sel),
      .preset_bus  (preset_bus),
      .remaining   (remaining),
      .C_out       (C_out),
      .busy        (busy),
      .err         (err),
      .active_ch   (active_ch)
   );

   always #5 C_CLK = ~C_CLK;

   function automatic logic [VAL_W-1:0] to_bcd(input int v);
      logic [VAL_W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reference: remaining time kept as a plain decimal integer.
   always @(posedge C_CLK) begin : ref_model
      int idx, val, weight, nib;
      bit ok, loaded;
      if (!RST) begin
         m_rem = 0; m_preset = 0; m_pre = 0; m_busy = 0;
         m_cout = 0; m_err = 0; m_active = '0;
      end else begin
         m_cout = 0;
         m_err = 0;
         loaded = 0;
         if (start) begin
            ok = ($countones(ch_sel) == 1);
            idx = 0;
            for (int k = 0; k < CHANNELS; k++) if (ch_sel[k]) idx = k;
            val = 0;
            weight = 1;
            for (int d = 0; d < DIGITS; d++) begin
               nib = int'(preset_bus[idx*VAL_W + d*4 +: 4]);
               if (nib > 9) ok = 0;
               val = val + nib * weight;
               weight = weight * 10;
            end
            if (ok) begin
               m_rem = val; m_preset = val; m_pre = 0;
               m_busy = 1; m_active = ch_sel; loaded = 1;
            end else begin
               m_err = 1;
            end
         end
         if (!loaded && m_busy && C_EN) begin
            if (m_pre == TICK_DIV - 1) begin
               m_pre = 0;
               if (m_rem > 0) m_rem = m_rem - 1;
               else begin
                  m_cout = 1;
                  if (auto_reload) m_rem = m_preset;
                  else m_busy = 0;
               end
            end else begin
               m_pre = m_pre + 1;
            end
         end
      end
   end

   task automatic cycle();
      @(posedge C_CLK);
      #1;
   endtask

   task automatic set_preset(input int ch, input logic [VAL_W-1:0] v);
      preset_bus[ch*VAL_W +: VAL_W] = v;
   endtask

   task automatic pulse_start(input logic [CHANNELS-1:0] sel);
      ch_sel = sel;
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      cycle();
      cycle();
      tests_run++;
      if (remaining !== '0 || C_out !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || active_ch !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: rem=%h cout=%b busy=%b err=%b act=%b, required all 0",
                  remaining, C_out, busy, err, active_ch);
      end
      RST = 1'b1;
      cycle();
   endtask

   task automatic test_basic_countdown();
      int first_done;
      logic [VAL_W-1:0] exp;
      auto_reload = 1'b0;
      C_EN = 1'b1;
      set_preset(0, 12'h012);
      pulse_start(4'b0001);
      first_done = -1;
      for (int n = 1; n <= 200 && first_done < 0; n++) begin
         cycle();
         if (C_out === 1'b1) first_done = n;
         else begin
            exp = to_bcd((n / TICK_DIV) >= 12 ? 0 : 12 - n / TICK_DIV);
            tests_run++;
            if (remaining !== exp) begin
               tests_failed++;
               $display("[TB] FAIL basic_rem n=%0d: got %h, required %h", n, remaining, exp);
            end
         end
      end
      tests_run++;
      if (first_done != 13 * TICK_DIV) begin
         tests_failed++;
         $display("[TB] FAIL basic_latency: got %0d, required %0d", first_done, 13 * TICK_DIV);
      end
      tests_run++;
      if (busy !== 1'b0 || remaining !== '0) begin
         tests_failed++;
         $display("[TB] FAIL basic_idle: busy=%b rem=%h, required 0/000", busy, remaining);
      end
      cycle();
      tests_run++;
      if (C_out !== 1'b0 || remaining !== '0) begin
         tests_failed++;
         $display("[TB] FAIL basic_pulse_width: cout=%b rem=%h, required 0/000", C_out, remaining);
      end
   endtask

   task automatic test_borrow_reload();
      logic [VAL_W-1:0] exp;
      auto_reload = 1'b1;
      set_preset(2, 12'h010);
      pulse_start(4'b0100);
      for (int n = 1; n < 11 * TICK_DIV; n++) begin
         cycle();
         exp = to_bcd(10 - n / TICK_DIV);
         tests_run++;
         if (remaining !== exp || C_out !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reload_seq n=%0d: rem=%h cout=%b busy=%b, required %h/0/1",
                     n, remaining, C_out, busy, exp);
         end
      end
      cycle();
      tests_run++;
      if (C_out !== 1'b1 || remaining !== 12'h010 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reload_expiry: cout=%b rem=%h busy=%b, required 1/010/1",
                  C_out, remaining, busy);
      end
      for (int n = 0; n < TICK_DIV; n++) cycle();
      tests_run++;
      if (remaining !== 12'h009 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reload_second_period: rem=%h busy=%b, required 009/1", remaining, busy);
      end
      auto_reload = 1'b0;
   endtask

   task automatic test_pause();
      int n, done_at;
      set_preset(1, 12'h008);
      pulse_start(4'b0010);
      for (n = 1; n <= 3 * TICK_DIV; n++) cycle();
      tests_run++;
      if (remaining !== 12'h005) begin
         tests_failed++;
         $display("[TB] FAIL pause_entry: got %h, required 005", remaining);
      end
      C_EN = 1'b0;
      for (int p = 0; p < 7; p++) begin
         cycle();
         n++;
         tests_run++;
         if (remaining !== 12'h005 || busy !== 1'b1 || C_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pause_hold p=%0d: rem=%h busy=%b cout=%b, required 005/1/0",
                     p, remaining, busy, C_out);
         end
      end
      C_EN = 1'b1;
      done_at = -1;
      for (int k = 0; k < 100 && done_at < 0; k++) begin
         cycle();
         if (C_out === 1'b1) done_at = n;
         n++;
      end
      tests_run++;
      if (done_at != 9 * TICK_DIV + 7) begin
         tests_failed++;
         $display("[TB] FAIL pause_latency: got %0d, required %0d", done_at, 9 * TICK_DIV + 7);
      end
   endtask

   task automatic test_rejects();
      set_preset(0, 12'h012);
      set_preset(1, 12'h004);
      set_preset(2, 12'h005);
      pulse_start(4'b0001);
      for (int n = 1; n <= 4; n++) cycle();
      pulse_start(4'b0110);
      tests_run++;
      if (err !== 1'b1 || remaining !== 12'h011 || active_ch !== 4'b0001 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reject_multihot: err=%b rem=%h act=%b busy=%b, required 1/011/0001/1",
                  err, remaining, active_ch, busy);
      end
      cycle();
      tests_run++;
      if (err !== 1'b0 || remaining !== 12'h010) begin
         tests_failed++;
         $display("[TB] FAIL reject_err_width: err=%b rem=%h, required 0/010", err, remaining);
      end
      set_preset(3, 12'h01A);
      pulse_start(4'b1000);
      tests_run++;
      if (err !== 1'b1 || remaining !== 12'h010 || active_ch !== 4'b0001) begin
         tests_failed++;
         $display("[TB] FAIL reject_badbcd: err=%b rem=%h act=%b, required 1/010/0001",
                  err, remaining, active_ch);
      end
      cycle();
      cycle();
      tests_run++;
      if (remaining !== 12'h009) begin
         tests_failed++;
         $display("[TB] FAIL reject_count_continues: got %h, required 009", remaining);
      end
   endtask

   task automatic test_restart();
      set_preset(0, 12'h012);
      set_preset(1, 12'h030);
      pulse_start(4'b0001);
      for (int n = 1; n <= 4; n++) cycle();
      pulse_start(4'b0010);
      tests_run++;
      if (remaining !== 12'h030 || active_ch !== 4'b0010 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL restart_load: rem=%h act=%b busy=%b, required 030/0010/1",
                  remaining, active_ch, busy);
      end
      cycle();
      cycle();
      tests_run++;
      if (remaining !== 12'h030) begin
         tests_failed++;
         $display("[TB] FAIL restart_prescaler_cleared: got %h, required 030", remaining);
      end
      cycle();
      tests_run++;
      if (remaining !== 12'h029) begin
         tests_failed++;
         $display("[TB] FAIL restart_first_tick: got %h, required 029", remaining);
      end
      RST = 1'b0;
      cycle();
      RST = 1'b1;
      tests_run++;
      if (remaining !== '0 || C_out !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || active_ch !== '0) begin
         tests_failed++;
         $display("[TB] FAIL midcount_reset: rem=%h cout=%b busy=%b err=%b act=%b, required all 0",
                  remaining, C_out, busy, err, active_ch);
      end
   endtask

   task automatic test_zero_and_width();
      set_preset(0, 12'h000);
      pulse_start(4'b0001);
      cycle();
      cycle();
      tests_run++;
      if (C_out !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL zero_early: cout=%b busy=%b, required 0/1", C_out, busy);
      end
      cycle();
      tests_run++;
      if (C_out !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL zero_expiry: cout=%b busy=%b, required 1/0", C_out, busy);
      end
      set_preset(0, 12'h100);
      pulse_start(4'b0001);
      for (int n = 0; n < TICK_DIV; n++) cycle();
      tests_run++;
      if (remaining !== 12'h099) begin
         tests_failed++;
         $display("[TB] FAIL borrow_100: got %h, required 099", remaining);
      end
   endtask

   task automatic test_random();
      logic [VAL_W-1:0] p;
      for (int n = 0; n < 1500; n++) begin
         RST = ($urandom_range(0, 199) != 0);
         C_EN = ($urandom_range(0, 5) != 0);
         auto_reload = $urandom_range(0, 1);
         start = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) != 0) ch_sel = 4'b0001 << $urandom_range(0, 3);
         else ch_sel = 4'($urandom);
         for (int k = 0; k < CHANNELS; k++) begin
            p = to_bcd(int'($urandom_range(0, 25)));
            if ($urandom_range(0, 9) == 0) p[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(10, 15));
            set_preset(k, p);
         end
         cycle();
         tests_run++;
         if (remaining !== to_bcd(m_rem) || C_out !== m_cout || busy !== m_busy ||
             err !== m_err || active_ch !== m_active) begin
            tests_failed++;
            $display("[TB] FAIL random n=%0d: rem=%h cout=%b busy=%b err=%b act=%b, required %h/%b/%b/%b/%b",
                     n, remaining, C_out, busy, err, active_ch,
                     to_bcd(m_rem), m_cout, m_busy, m_err, m_active);
         end
      end
      start = 1'b0;
      RST = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_countdown();
      test_borrow_reload();
      test_pause();
      test_rejects();
      test_restart();
      test_zero_and_width();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
